// File: rtl/uop_pkg.sv
// Micro-op field layout shared by the dispatch path:
// {UOP[6:0], BrM, Tag, prd, pr2, pr1, val, p2, p1}, MSB to LSB.
package uop_pkg;
  localparam int NUM_WDEST     = 4;
  localparam int UOP_OP_W      = 7;
  localparam int DEF_WIDTH_REG = 3;
  localparam int DEF_WIDTH_TAG = 3;
  localparam int DEF_WIDTH_BRM = 3;

  localparam int P1_BIT  = 0;
  localparam int P2_BIT  = 1;
  localparam int VAL_BIT = 2;
  localparam int PR1_LSB = 3;

  function automatic int pr2_lsb(input int wr);
    return PR1_LSB + wr;
  endfunction

  function automatic int prd_lsb(input int wr);
    return PR1_LSB + 2 * wr;
  endfunction

  function automatic int tag_lsb(input int wr);
    return PR1_LSB + 3 * wr;
  endfunction

  function automatic int brm_lsb(input int wr, input int wt);
    return tag_lsb(wr) + wt;
  endfunction

  function automatic int uop_lsb(input int wr, input int wt, input int wb);
    return brm_lsb(wr, wt) + wb;
  endfunction

  function automatic int uop_width(input int wr, input int wt, input int wb);
    return UOP_OP_W + wb + wt + 3 * wr + 3;
  endfunction

  // Offsets for the default field widths.
  localparam int PR2_LSB = pr2_lsb(DEF_WIDTH_REG);
  localparam int PRD_LSB = prd_lsb(DEF_WIDTH_REG);
  localparam int TAG_LSB = tag_lsb(DEF_WIDTH_REG);
  localparam int BRM_LSB = brm_lsb(DEF_WIDTH_REG, DEF_WIDTH_TAG);
  localparam int UOP_LSB = uop_lsb(DEF_WIDTH_REG, DEF_WIDTH_TAG, DEF_WIDTH_BRM);
  localparam int WIDTH   = uop_width(DEF_WIDTH_REG, DEF_WIDTH_TAG, DEF_WIDTH_BRM);
endpackage

// File: rtl/uop_wake_kill.sv
// Combinational update of one micro-op: sets p1/p2 on a wakeup tag match and
// clears val when any of its branch-mask bits is being killed.
module uop_wake_kill
  import uop_pkg::*;
#(
  parameter int WIDTH_REG = 3,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_BRM = 3,
  localparam int WIDTH    = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
  input  logic [WIDTH-1:0]               uop_in,
  input  logic [NUM_WDEST*WIDTH_REG-1:0] wdest4x,
  input  logic [WIDTH_BRM-1:0]           br_kill,
  output logic [WIDTH-1:0]               uop_out
);
  localparam int PR2_L = pr2_lsb(WIDTH_REG);
  localparam int BRM_L = brm_lsb(WIDTH_REG, WIDTH_TAG);

  logic [WIDTH_REG-1:0] pr1;
  logic [WIDTH_REG-1:0] pr2;
  logic [WIDTH_BRM-1:0] brm;

  assign pr1 = uop_in[PR1_LSB +: WIDTH_REG];
  assign pr2 = uop_in[PR2_L +: WIDTH_REG];
  assign brm = uop_in[BRM_L +: WIDTH_BRM];

  // Ready bits only ever set; there is no null wakeup tag.
  always_comb begin
    uop_out = uop_in;
    for (int i = 0; i < NUM_WDEST; i++) begin
      if (wdest4x[i*WIDTH_REG +: WIDTH_REG] == pr1) uop_out[P1_BIT] = 1'b1;
      if (wdest4x[i*WIDTH_REG +: WIDTH_REG] == pr2) uop_out[P2_BIT] = 1'b1;
    end
    if (|(brm & br_kill)) uop_out[VAL_BIT] = 1'b0;
  end
endmodule

// File: rtl/dispatch_buffer.sv
// 4-wide bundle FIFO between dispatch and the issue queue; keeps held uops current
// with wakeups and kills. Optional DISPBUF_KILL_DROP_EN auto-drops fully killed heads.
module dispatch_buffer
  import uop_pkg::*;
#(
  parameter int WIDTH_REG = 3,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_BRM = 3,
  parameter int DEPTH     = 2,
  localparam int WIDTH    = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [WIDTH-1:0]               i_inst1,
  input  logic [WIDTH-1:0]               i_inst2,
  input  logic [WIDTH-1:0]               i_inst3,
  input  logic [WIDTH-1:0]               i_inst4,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [WIDTH-1:0]               o_inst1,
  output logic [WIDTH-1:0]               o_inst2,
  output logic [WIDTH-1:0]               o_inst3,
  output logic [WIDTH-1:0]               o_inst4,
  output logic                           o_valid,
  input  logic                           i_ready,
  input  logic [NUM_WDEST*WIDTH_REG-1:0] i_wdest4x,
  input  logic [WIDTH_BRM-1:0]           i_BrKill
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = 4;

  logic [WIDTH-1:0] mem      [DEPTH][LANES];
  logic [WIDTH-1:0] mem_upd  [DEPTH][LANES];
  logic [WIDTH-1:0] in_raw   [LANES];
  logic [WIDTH-1:0] in_upd   [LANES];
  logic [WIDTH-1:0] head_raw [LANES];
  logic [WIDTH-1:0] head_upd [LANES];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, not_empty, not_full;

  assign in_raw[0] = i_inst1;
  assign in_raw[1] = i_inst2;
  assign in_raw[2] = i_inst3;
  assign in_raw[3] = i_inst4;

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      uop_wake_kill #(.WIDTH_REG(WIDTH_REG), .WIDTH_TAG(WIDTH_TAG), .WIDTH_BRM(WIDTH_BRM))
        u_store (.uop_in(mem[e][l]), .wdest4x(i_wdest4x), .br_kill(i_BrKill), .uop_out(mem_upd[e][l]));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_port
    assign head_raw[l] = mem[rd_ptr][l];
    uop_wake_kill #(.WIDTH_REG(WIDTH_REG), .WIDTH_TAG(WIDTH_TAG), .WIDTH_BRM(WIDTH_BRM))
      u_in (.uop_in(in_raw[l]), .wdest4x(i_wdest4x), .br_kill(i_BrKill), .uop_out(in_upd[l]));
    uop_wake_kill #(.WIDTH_REG(WIDTH_REG), .WIDTH_TAG(WIDTH_TAG), .WIDTH_BRM(WIDTH_BRM))
      u_out (.uop_in(head_raw[l]), .wdest4x(i_wdest4x), .br_kill(i_BrKill), .uop_out(head_upd[l]));
  end

  assign o_inst1 = head_upd[0];
  assign o_inst2 = head_upd[1];
  assign o_inst3 = head_upd[2];
  assign o_inst4 = head_upd[3];

  // Handshake: a bundle moves in on i_valid && o_ready and out on o_valid && i_ready.
  // Both flags come from the registered count (reset only forces them low).
  assign not_empty = (count != '0);
  assign not_full  = (count != CW'(DEPTH));
  assign o_ready   = !i_rst && not_full;
  assign push      = i_valid && o_ready;

`ifdef DISPBUF_KILL_DROP_EN
  logic any_val;
  assign any_val = head_upd[0][VAL_BIT] | head_upd[1][VAL_BIT] |
                   head_upd[2][VAL_BIT] | head_upd[3][VAL_BIT];
  assign o_valid = !i_rst && not_empty && any_val;
  // A fully killed head is dequeued silently, independent of i_ready.
  assign pop     = !i_rst && not_empty && (i_ready || !any_val);
`else
  assign o_valid = !i_rst && not_empty;
  assign pop     = o_valid && i_ready;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < DEPTH; e++)
        for (int l = 0; l < LANES; l++)
          mem[e][l] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        for (int l = 0; l < LANES; l++)
          mem[e][l] <= mem_upd[e][l];
      if (push) begin
        for (int l = 0; l < LANES; l++) mem[wr_ptr][l] <= in_upd[l];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed, table-driven bench for dispatch_buffer (default parameters).
module tb_dispatch_buffer;
  localparam int W  = 25;
  localparam int WD = 12;

  typedef logic [3:0][W-1:0] bundle_t;
  typedef struct {
    logic          rst, vld, rdy;
    bundle_t       ins;
    logic [WD-1:0] wd;
    logic [2:0]    kill;
    logic          ev, er, chk;
    bundle_t       eo;
  } vec_t;

  localparam logic [WD-1:0] IDLE = {4{3'h6}};
  localparam logic [WD-1:0] WK   = {3'h6, 3'h5, 3'h6, 3'h6};
  localparam logic [WD-1:0] WP2  = {3'h4, 3'h6, 3'h6, 3'h6};
  localparam logic [11:0]   BRMK = {3'b000, 3'b010, 3'b101, 3'b010};
  localparam logic [11:0]   BRMA = {4{3'b010}};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  bundle_t       ins = '0;
  logic [WD-1:0] wd = IDLE;
  logic [2:0]    kill = '0;
  logic [W-1:0]  o1, o2, o3, o4;
  logic          o_valid, o_ready;

  int tests = 0;
  int fails = 0;

  dispatch_buffer dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst1(ins[0]), .i_inst2(ins[1]), .i_inst3(ins[2]), .i_inst4(ins[3]),
    .i_valid(i_valid), .o_ready(o_ready),
    .o_inst1(o1), .o_inst2(o2), .o_inst3(o3), .o_inst4(o4),
    .o_valid(o_valid), .i_ready(i_ready),
    .i_wdest4x(wd), .i_BrKill(kill)
  );

  function automatic bundle_t bun(input int k, input logic [11:0] brm, input logic [3:0] val,
                                  input logic p2, input logic p1);
    bundle_t b;
    for (int l = 0; l < 4; l++)
      b[l] = {7'(k * 4 + l), brm[l*3 +: 3], 3'(l), 3'h1, 3'h4, 3'h5, val[l], p2, p1};
    return b;
  endfunction

  function automatic bundle_t b(input int k);
    return bun(k, 12'h0, 4'hF, 1'b0, 1'b0);
  endfunction

  function automatic vec_t v(input int rst_v, input int vld, input int rdy, input bundle_t in_b,
                             input logic [WD-1:0] wdv, input int killv, input int ev, input int er,
                             input int chk, input bundle_t eo);
    vec_t t;
    t.rst = (rst_v != 0); t.vld = (vld != 0); t.rdy = (rdy != 0);
    t.ins = in_b; t.wd = wdv; t.kill = 3'(killv);
    t.ev = (ev != 0); t.er = (er != 0); t.chk = (chk != 0); t.eo = eo;
    return t;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // driver: inputs at negedge, outputs sampled 1ns later, before the next posedge
  task automatic apply(input vec_t t, input string nm);
    bundle_t got;
    @(negedge clk);
    rst = t.rst; i_valid = t.vld; i_ready = t.rdy;
    ins = t.ins; wd = t.wd; kill = t.kill;
    #1;
    got = {o4, o3, o2, o1};
    check({nm, " valid"}, W'(o_valid), W'(t.ev));
    check({nm, " ready"}, W'(o_ready), W'(t.er));
    if (t.chk)
      for (int l = 0; l < 4; l++)
        check($sformatf("%s lane%0d", nm, l), got[l], t.eo[l]);
  endtask

  vec_t tbl[21];

  initial begin
    // reset, single push + wakeup, fill/drain, streaming push/pop
    tbl[0]  = v(1, 0, 0, '0,   IDLE, 0, 0, 0, 0, '0);
    tbl[1]  = v(1, 0, 0, '0,   IDLE, 0, 0, 0, 0, '0);
    tbl[2]  = v(0, 0, 0, '0,   IDLE, 0, 0, 1, 0, '0);
    tbl[3]  = v(0, 1, 0, b(1), IDLE, 0, 0, 1, 0, '0);
    tbl[4]  = v(0, 0, 0, '0,   IDLE, 0, 1, 1, 1, b(1));
    tbl[5]  = v(0, 0, 0, '0,   WK,   0, 1, 1, 1, bun(1, 12'h0, 4'hF, 1'b0, 1'b1));
    tbl[6]  = v(0, 0, 0, '0,   IDLE, 0, 1, 1, 1, bun(1, 12'h0, 4'hF, 1'b0, 1'b1));
    tbl[7]  = v(0, 1, 0, b(2), IDLE, 0, 1, 1, 1, bun(1, 12'h0, 4'hF, 1'b0, 1'b1));
    tbl[8]  = v(0, 1, 0, b(4), IDLE, 0, 1, 0, 1, bun(1, 12'h0, 4'hF, 1'b0, 1'b1));
    tbl[9]  = v(0, 1, 1, b(3), IDLE, 0, 1, 0, 1, bun(1, 12'h0, 4'hF, 1'b0, 1'b1));
    tbl[10] = v(0, 0, 1, '0,   IDLE, 0, 1, 1, 1, b(2));
    tbl[11] = v(0, 0, 0, '0,   IDLE, 0, 0, 1, 0, '0);
    tbl[12] = v(0, 1, 0, b(5), IDLE, 0, 0, 1, 0, '0);
    for (int k = 6; k <= 11; k++)
      tbl[k + 7] = v(0, 1, 1, b(k), IDLE, 0, 1, 1, 1, b(k - 1));
    tbl[19] = v(0, 0, 1, '0,   IDLE, 0, 1, 1, 1, b(11));
    tbl[20] = v(0, 0, 0, '0,   IDLE, 0, 0, 1, 0, '0);

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // kill on a stored head, then wakeup of pr2, then kill applied at write
    apply(v(0, 1, 0, bun(20, BRMK, 4'hF, 1'b0, 1'b0), IDLE, 0, 0, 1, 0, '0), "kill_push");
    apply(v(0, 0, 0, '0, IDLE, 3'b010, 1, 1, 1, bun(20, BRMK, 4'b1010, 1'b0, 1'b0)), "kill_now");
    apply(v(0, 0, 0, '0, IDLE, 0,      1, 1, 1, bun(20, BRMK, 4'b1010, 1'b0, 1'b0)), "kill_held");
    apply(v(0, 0, 0, '0, WP2,  0,      1, 1, 1, bun(20, BRMK, 4'b1010, 1'b1, 1'b0)), "wake_p2");
    apply(v(0, 0, 1, '0, IDLE, 0,      1, 1, 1, bun(20, BRMK, 4'b1010, 1'b1, 1'b0)), "p2_held");
    apply(v(0, 1, 0, bun(21, BRMK, 4'hF, 1'b0, 1'b0), IDLE, 3'b010, 0, 1, 0, '0), "kill_wr");
    apply(v(0, 0, 1, '0, IDLE, 0,      1, 1, 1, bun(21, BRMK, 4'b1010, 1'b0, 1'b0)), "kill_wr_out");
    apply(v(0, 0, 0, '0, IDLE, 0,      0, 1, 0, '0), "kill_empty");

    // fully killed head bundle followed by a live one
    apply(v(0, 1, 0, bun(30, BRMA, 4'hF, 1'b0, 1'b0), IDLE, 0, 0, 1, 0, '0), "drop_push_a");
    apply(v(0, 1, 0, b(12), IDLE, 0, 1, 1, 1, bun(30, BRMA, 4'hF, 1'b0, 1'b0)), "drop_push_b");
`ifdef DISPBUF_KILL_DROP_EN
    apply(v(0, 0, 0, '0, IDLE, 3'b010, 0, 0, 0, '0),    "drop_kill");
    apply(v(0, 0, 0, '0, IDLE, 0,      1, 1, 1, b(12)), "drop_next");
    apply(v(0, 0, 1, '0, IDLE, 0,      1, 1, 1, b(12)), "drop_pop");
    apply(v(0, 0, 1, '0, IDLE, 0,      0, 1, 0, '0),    "drop_empty");
`else
    apply(v(0, 0, 0, '0, IDLE, 3'b010, 1, 0, 1, bun(30, BRMA, 4'h0, 1'b0, 1'b0)), "drop_kill");
    apply(v(0, 0, 0, '0, IDLE, 0,      1, 0, 1, bun(30, BRMA, 4'h0, 1'b0, 1'b0)), "drop_held");
    apply(v(0, 0, 1, '0, IDLE, 0,      1, 0, 1, bun(30, BRMA, 4'h0, 1'b0, 1'b0)), "drop_pop_a");
    apply(v(0, 0, 1, '0, IDLE, 0,      1, 1, 1, b(12)), "drop_pop_b");
`endif
    apply(v(0, 0, 0, '0, IDLE, 0, 0, 1, 0, '0), "final_empty");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- 4-wide skid/decoupling FIFO between rename/dispatch and the issue queue (`queue4in2`).
- Holds whole dispatch bundles of four micro-ops while the queue back-pressures.
- Keeps held micro-ops current: applies wakeup broadcasts (`i_wdest4x`) and branch kills (`i_BrKill`) every cycle, so no broadcast is missed while a bundle waits.

Parameters:
- WIDTH_REG, 3, physical register index width
- WIDTH_TAG, 3, ROB tag width
- WIDTH_BRM, 3, branch mask width
- DEPTH, 2, bundle entries (power of two, >=2)
- WIDTH, 7+WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+3, micro-op width (derived localparam)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_inst1..i_inst4  in  WIDTH  incoming bundle lanes 1..4
- i_valid  in  1  incoming bundle present
- o_ready  out  1  buffer can accept a bundle this cycle
- o_inst1..o_inst4  out  WIDTH  head bundle lanes, wakeup/kill applied
- o_valid  out  1  head bundle present
- i_ready  in  1  issue queue takes head bundle (queue `i_en`)
- i_wdest4x  in  4*WIDTH_REG  four wakeup destination tags, lane0 in LSBs
- i_BrKill  in  WIDTH_BRM  branch-kill mask

Behaviour:
- Micro-op layout, MSB to LSB: {UOP[6:0], BrM, Tag, prd, pr2, pr1, val, p2, p1}. Bit0=p1, bit1=p2, bit2=val.
- Interface fact: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset (`i_rst`=1 at edge):
  - wr_ptr=rd_ptr=0, count=0, all stored val/p bits cleared.
  - o_valid=0 and o_ready=0 while `i_rst` is high; o_ready=1 on the first cycle after.
- Push and pop:
  - Push when i_valid&&o_ready; pop when o_valid&&i_ready.
  - o_ready = (count!=DEPTH).
  - o_valid = (count!=0).
  - Both outputs are combinational from registered count only; no input-to-output path.
- Latency:
  - A bundle pushed at edge N is presented at the output from cycle N+1.
  - No flow-through when empty.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full with pop: o_ready stays 0 that cycle. No same-cycle refill.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Wakeup, per lane, per stored entry, every cycle:
  - p1<=1 if pr1 equals any of the 4 wdest fields; p2 likewise for pr2.
  - p bits never clear.
  - The same update applies to the incoming bundle at write.
  - No null encoding: idle wdest lanes must carry the tag of an always-ready register.
- Kill:
  - A uop is killed when |(BrM & i_BrKill).
  - A kill clears val in storage and in the incoming bundle at write.
  - Entries are not removed; the queue ignores val=0 uops.
- Output forwarding: o_instN = stored head lane with the current-cycle wakeup and kill applied combinationally. A broadcast coinciding with the pop cycle is therefore seen by the queue.
- Invalid input lanes (val=0) are stored unchanged apart from the wakeup/kill rules.

Optional Feature:
- Macro: DISPBUF_KILL_DROP_EN.
- Defined:
  - A head bundle whose four (forwarded) val bits are all 0 is auto-popped without asserting o_valid; it is dequeued regardless of i_ready.
  - o_valid = (count!=0) && any forwarded val.
- Undefined: empty bundles are presented normally and popped only on i_ready.

Decomposition:
- Shared package `uop_pkg` holds:
  - field offset/width localparams (P1_BIT, P2_BIT, VAL_BIT, PR1_LSB, PR2_LSB, PRD_LSB, TAG_LSB, BRM_LSB, UOP_LSB);
  - the WIDTH formula;
  - wdest lane count (4).
- One combinational sub-module `uop_wake_kill`:
  - inputs: uop, wdest4x, BrKill; output: updated uop.
  - Instantiated 4 per stored entry, plus 4 at write, plus 4 on the output path.

Test Plan:
1. Reset then idle: i_rst=1 for 2 cycles -> o_valid=0, o_ready=0 during reset; o_ready=1 next cycle, o_valid=0.
2. Push one bundle with i_ready=0:
   - Stimulus: all lanes val=1, pr1=3'h5, p1=0; wdest4x={4{3'h6}}.
   - Cycle +1: o_valid=1 and o_inst match input.
   - Then wdest lane2=3'h5 -> same cycle, o_instN p1=1 on the output; the bit stays 1 after wdest returns to 6.
3. Fill DEPTH=2 with i_ready=0 -> o_ready=0 after 2 pushes. A third i_valid is ignored. Then i_ready=1 for 2 cycles -> bundles emerge in push order and o_ready=1 again.
4. Simultaneous push/pop at count=1 for 6 cycles -> count stays 1, pointers wrap, output order matches input order, no loss or duplication.
5. Kill: stored lane with BrM=3'b010, i_BrKill=3'b010 -> that lane's val=0 on the output the same cycle and in storage afterwards. A lane with BrM=3'b101 is unaffected.
6. With DISPBUF_KILL_DROP_EN: kill all four lanes of the head with i_ready=0 -> o_valid stays 0, the bundle is dropped next edge and the second bundle appears. Without the macro: o_valid=1 with all val=0.
